// File: rtl/iterative_divider.sv
// iterative_divider
// Multi-cycle signed divide/modulo unit. One operand pair is accepted per
// start strobe while idle. A restoring shift-subtract loop produces one
// quotient bit per clock on operand magnitudes. A final fix-up cycle then
// applies the signs and registers every output together with a one-cycle
// done pulse.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   start      request strobe, accepted only while busy is low
//   modulo     0: result = quotient, 1: result = remainder (latched at accept)
//   dest       signed dividend (latched at accept)
//   src        signed divisor (latched at accept)
//   busy       high from the edge after accept until the completing edge
//   done       single-cycle pulse, outputs valid in that cycle
//   quotient   signed quotient, truncated toward zero
//   remainder  signed remainder, sign follows the dividend
//   result     quotient or remainder, selected by the latched mode
//   flags      {overflow, parity, negative, zero, carry} derived from result
module iterative_divider #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  modulo,
  input  logic [DATA_WIDTH-1:0] dest,
  input  logic [DATA_WIDTH-1:0] src,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            flags
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

  state_t state, state_next;

  logic [CW-1:0] count;
  logic [W:0]    rem;        // partial remainder, one bit wider than the data
  logic [W-1:0]  quo;        // dividend magnitude shifting out, quotient shifting in
  logic [W:0]    dvs;        // divisor magnitude; |-2^(W-1)| is exact in W+1 bits
  logic [W-1:0]  dest_lat;   // original dividend, returned as remainder on divide-by-zero
  logic          mod_lat;
  logic          q_neg;      // operand signs differ
  logic          div_zero;
  logic          min_ovf;    // most-negative dividend divided by -1

  logic [W-1:0]  dest_mag;
  logic [W-1:0]  src_mag;
  logic [W:0]    shifted;
  logic [W+1:0]  diff;

  logic [W-1:0]  fix_q;
  logic [W-1:0]  fix_r;
  logic [W-1:0]  fix_res;
  logic          fix_ovf;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    unique case (state)
      IDLE:    if (start) state_next = DIVIDE;
      DIVIDE: begin
        busy = 1'b1;
        if (count == LAST_ITER) state_next = FIXUP;
      end
      FIXUP: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Two's-complement magnitudes; -(-2^(W-1)) wraps to 2^(W-1), which is the
  // correct magnitude when read as unsigned.
  assign dest_mag = dest[W-1] ? -dest : dest;
  assign src_mag  = src[W-1]  ? -src  : src;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and trial-subtract. diff[W+1] set means the trial went negative.
  assign shifted = (rem << 1) | {{W{1'b0}}, quo[W-1]};
  assign diff    = {1'b0, shifted} - {1'b0, dvs};

  always_comb begin
    fix_q   = q_neg ? -quo : quo;
    fix_r   = dest_lat[W-1] ? -rem[W-1:0] : rem[W-1:0];
    fix_ovf = 1'b0;
    if (div_zero) begin
      fix_q   = '1;
      fix_r   = dest_lat;
      fix_ovf = 1'b1;
    end else if (min_ovf) begin
      // Magnitude path already yields 2^(W-1) with both signs negative.
      fix_ovf = 1'b1;
    end
    fix_res = mod_lat ? fix_r : fix_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      dest_lat  <= '0;
      mod_lat   <= 1'b0;
      q_neg     <= 1'b0;
      div_zero  <= 1'b0;
      min_ovf   <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      result    <= '0;
      flags     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count    <= '0;
            rem      <= '0;
            quo      <= dest_mag;
            dvs      <= {1'b0, src_mag};
            dest_lat <= dest;
            mod_lat  <= modulo;
            q_neg    <= dest[W-1] ^ src[W-1];
            div_zero <= (src == '0);
            min_ovf  <= (dest == {1'b1, {(W-1){1'b0}}}) && (src == '1);
          end
        end
        DIVIDE: begin
          if (!diff[W+1]) begin
            rem <= diff[W:0];
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[W-2:0], 1'b0};
          end
          count <= count + 1'b1;
        end
        FIXUP: begin
          quotient  <= fix_q;
          remainder <= fix_r;
          result    <= fix_res;
          flags     <= {fix_ovf, ~^fix_res, fix_res[W-1], fix_res == '0, 1'b0};
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: reset state, a table of
// directed vectors (issued back-to-back), a start pulse during an operation,
// reset mid-operation, and randomized operands against an arithmetic model.
module tb_iterative_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        modulo;
  logic [15:0] dest;
  logic [15:0] src;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic [15:0] result;
  logic [4:0]  flags;

  int tests  = 0;
  int failed = 0;

  iterative_divider #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .modulo    (modulo),
    .dest      (dest),
    .src       (src),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] dest;
    logic [15:0] src;
    logic        modulo;
    logic [15:0] exp_q;
    logic [15:0] exp_r;
    logic [15:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic (truncating division, remainder
  // sign follows the dividend) plus the two special cases.
  function automatic void model(input logic [15:0] d, input logic [15:0] s, input logic m,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic [15:0] res, output logic [4:0] f);
    int   a;
    int   b;
    logic ovf;
    a = int'($signed(d));
    b = int'($signed(s));
    if (b == 0) begin
      q = 16'hFFFF; r = d; ovf = 1'b1;
    end else if (a == -32768 && b == -1) begin
      q = 16'h8000; r = 16'h0000; ovf = 1'b1;
    end else begin
      q = 16'(a / b); r = 16'(a % b); ovf = 1'b0;
    end
    res = m ? r : q;
    f   = {ovf, ~^res, res[15], res == 16'h0000, 1'b0};
  endfunction

  // Issues one request (the start is driven in the current cycle) and waits
  // for done. lat counts rising edges after the accept edge; -1 on timeout.
  // A start strobe with junk operands is injected when lat == glitch_at.
  task automatic do_op(input logic [15:0] d, input logic [15:0] s, input logic m,
                       input int glitch_at, output int lat);
    @(negedge clk);
    dest = d; src = s; modulo = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dest = 16'($urandom); src = 16'($urandom); modulo = 1'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("done_low_after_accept", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == glitch_at) begin
        start = 1'b1; dest = 16'h0005; src = 16'h0001; modulo = ~m;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    if (!done) lat = -1;
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t        vecs[11];
  int          lat;
  logic [15:0] eq, er, eres;
  logic [4:0]  ef;
  logic [15:0] rd, rs;
  logic        rm;
  logic        seen_done;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"basic_div",   16'd9,     16'd2,     1'b0, 16'd4,     16'd1,     16'd4,     5'd0};
    vecs[1]  = '{"basic_mod",   16'd9,     16'd2,     1'b1, 16'd4,     16'd1,     16'd1,     5'd0};
    vecs[2]  = '{"neg_div",     16'hFFF9,  16'd2,     1'b0, 16'hFFFD,  16'hFFFF,  16'hFFFD,  5'd4};
    vecs[3]  = '{"neg_mod",     16'hFFF9,  16'd2,     1'b1, 16'hFFFD,  16'hFFFF,  16'hFFFF,  5'd12};
    vecs[4]  = '{"zero_mod",    16'd4,     16'd2,     1'b1, 16'd2,     16'd0,     16'd0,     5'd10};
    vecs[5]  = '{"div_zero",    16'h1234,  16'd0,     1'b0, 16'hFFFF,  16'h1234,  16'hFFFF,  5'd28};
    vecs[6]  = '{"div_zero_mod",16'h1234,  16'd0,     1'b1, 16'hFFFF,  16'h1234,  16'h1234,  5'd16};
    vecs[7]  = '{"overflow",    16'h8000,  16'hFFFF,  1'b0, 16'h8000,  16'd0,     16'h8000,  5'd20};
    vecs[8]  = '{"pos_by_neg",  16'd7,     16'hFFFE,  1'b0, 16'hFFFD,  16'd1,     16'hFFFD,  5'd4};
    vecs[9]  = '{"min_by_one",  16'h8000,  16'd1,     1'b1, 16'h8000,  16'd0,     16'd0,     5'd10};
    vecs[10] = '{"min_by_min",  16'h8000,  16'h8000,  1'b0, 16'd1,     16'd0,     16'd1,     5'd0};

    reset = 1'b1; start = 1'b0; modulo = 1'b0; dest = '0; src = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      {31'd0, busy},   32'd0);
    check("rst_done",      {31'd0, done},   32'd0);
    check("rst_quotient",  {16'd0, quotient},  32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_result",    {16'd0, result},    32'd0);
    check("rst_flags",     {27'd0, flags},     32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table; each request is issued in the done cycle of the
    // previous one, so these also exercise back-to-back acceptance.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].dest, vecs[i].src, vecs[i].modulo, -1, lat);
      check({vecs[i].name, "_latency"},  32'(lat), 32'd17);
      check({vecs[i].name, "_quotient"}, {16'd0, quotient},  {16'd0, vecs[i].exp_q});
      check({vecs[i].name, "_remainder"},{16'd0, remainder}, {16'd0, vecs[i].exp_r});
      check({vecs[i].name, "_result"},   {16'd0, result},    {16'd0, vecs[i].exp_res});
      check({vecs[i].name, "_flags"},    {27'd0, flags},     {27'd0, vecs[i].exp_flags});
    end

    // Done is a single pulse and outputs hold afterwards.
    repeat (3) @(posedge clk);
    #1;
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("hold_quotient", {16'd0, quotient}, 32'd1);
    check("hold_result",   {16'd0, result},   32'd1);

    // Start pulsed 5 cycles into an operation is ignored.
    do_op(16'd100, 16'd7, 1'b0, 5, lat);
    check("ignore_start_latency",  32'(lat), 32'd17);
    check("ignore_start_quotient", {16'd0, quotient},  32'd14);
    check("ignore_start_remainder",{16'd0, remainder}, 32'd2);
    check("ignore_start_result",   {16'd0, result},    32'd14);
    @(posedge clk); #1;
    check("ignore_start_no_second_op", {31'd0, busy}, 32'd0);

    // Reset on the 8th edge of an operation abandons it.
    @(negedge clk);
    dest = 16'h7FFF; src = 16'd3; modulo = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",      {31'd0, busy},      32'd0);
    check("midrst_done",      {31'd0, done},      32'd0);
    check("midrst_quotient",  {16'd0, quotient},  32'd0);
    check("midrst_remainder", {16'd0, remainder}, 32'd0);
    check("midrst_result",    {16'd0, result},    32'd0);
    check("midrst_flags",     {27'd0, flags},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen_done}, 32'd0);

    // Randomized operands against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0:       begin rd = 16'($urandom); rs = 16'h0000; end
        1:       begin rd = 16'h8000; rs = 16'hFFFF; end
        2:       begin rd = 16'($signed(8'($urandom))); rs = 16'($signed(4'($urandom))); end
        3:       begin rd = 16'h8000; rs = 16'($urandom); end
        default: begin rd = 16'($urandom); rs = 16'($urandom); end
      endcase
      rm = 1'($urandom);
      model(rd, rs, rm, eq, er, eres, ef);
      do_op(rd, rs, rm, -1, lat);
      check("rand_latency",   32'(lat), 32'd17);
      check("rand_quotient",  {16'd0, quotient},  {16'd0, eq});
      check("rand_remainder", {16'd0, remainder}, {16'd0, er});
      check("rand_result",    {16'd0, result},    {16'd0, eres});
      check("rand_flags",     {27'd0, flags},     {27'd0, ef});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle signed divide/modulo unit for the 16-bit datapath. It serves DIV and MOD operations that are too costly to resolve in one ALU cycle. It accepts one operand pair per start strobe and runs a restoring shift-subtract loop, one quotient bit per clock. It returns quotient, remainder, the selected result and an sFlags word with a one-cycle done pulse. It sits beside ArithmeticLogicUnit; control stalls on OutBusy and writes OutResult/OutFlags back on OutDone.

## Interface
- DataWidth, 16 (InstructionSetPkg): operand/result width.
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high.
- InStart  input  1  request strobe; accepted only when OutBusy=0.
- InModulo  input  1  0 = DIV (OutResult = quotient), 1 = MOD (OutResult = remainder); latched at accept.
- InDest  input  DataWidth  signed dividend; latched at accept.
- InSrc  input  DataWidth  signed divisor; latched at accept.
- OutBusy  output  1  high from the edge after accept until the completing edge.
- OutDone  output  1  single-cycle pulse; results valid in that cycle.
- OutQuotient  output  DataWidth  signed quotient.
- OutRemainder  output  DataWidth  signed remainder.
- OutResult  output  DataWidth  quotient or remainder per latched InModulo.
- OutFlags  output  sFlags  flags from OutResult: bit0 Carry, bit1 Zero, bit2 Negative, bit3 Parity, bit4 Overflow.

## Operation
- States: IDLE, DIVIDE, FIXUP.
- IDLE:
  - When InStart=1, latch operands and mode, and record the operand signs.
  - Load the magnitudes |InDest| and |InSrc| into the working registers.
  - Clear the bit counter and go to DIVIDE.
- DIVIDE:
  - Each cycle, shift {partial remainder, dividend} left by one.
  - Trial-subtract the divisor magnitude. Keep the result if it is non-negative and shift in quotient bit 1; otherwise restore and shift in 0.
  - After DataWidth iterations, go to FIXUP.
  - Work in DataWidth+1 bits so that |−32768| = 32768 is exact.
- FIXUP:
  - Negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. This gives truncation toward zero, with the remainder sign following the dividend.
  - Register all outputs, pulse OutDone and return to IDLE.
- Divisor = 0: latency is unchanged. FIXUP forces OutQuotient=16'hFFFF, OutRemainder=dividend and Overflow=1.
- Dividend 16'h8000 with divisor 16'hFFFF: OutQuotient=16'h8000, OutRemainder=0, Overflow=1.
- Flags:
  - Zero = (OutResult==0).
  - Negative = OutResult[MSB].
  - Parity = 1 when OutResult has an even number of ones.
  - Carry = 0 always.
  - Overflow = 1 only in the two cases above.
- InStart while OutBusy=1 is ignored; no queueing, no corruption of the operation in flight.
- OutQuotient, OutRemainder, OutResult and OutFlags hold their values until the next FIXUP or Reset.

## Timing
- Reset: state IDLE. OutBusy=0, OutDone=0, OutQuotient=0, OutRemainder=0, OutResult=0, OutFlags=0, counter=0.
- Reset asserted mid-operation: the operation is abandoned on that edge and all outputs take their reset values. No OutDone is produced for the abandoned request.
- Latency: the accept edge is E0. OutDone is high in the cycle following edge E0+DataWidth+1, i.e. 17 cycles for DataWidth=16, for every operand value.
- OutBusy is high from E0 through the cycle before OutDone. It is low in the OutDone cycle.
- Because OutBusy is low in the OutDone cycle, a new InStart in that cycle is accepted, giving back-to-back throughput of one result per DataWidth+1 cycles.
- InDest/InSrc/InModulo may change freely after the accept edge.

## Test plan
- Basic DIV and MOD: InDest=9, InSrc=2, InModulo=0 -> after 17 cycles OutDone=1, OutQuotient=4, OutRemainder=1, OutResult=4, OutFlags=0. Repeat with InModulo=1 -> OutResult=1, OutFlags=0.
- Signed operands: InDest=16'hFFF9 (−7), InSrc=2, DIV -> OutQuotient=16'hFFFD, OutRemainder=16'hFFFF, OutFlags=sFlags'(4).
- Zero result: InDest=4, InSrc=2, MOD -> OutResult=0, OutFlags=sFlags'(10) (Zero+Parity).
- Divide by zero: InDest=16'h1234, InSrc=0, DIV -> OutQuotient=16'hFFFF, OutRemainder=16'h1234, OutFlags=sFlags'(28), latency still 17.
- Overflow: InDest=16'h8000, InSrc=16'hFFFF, DIV -> OutQuotient=16'h8000, OutRemainder=0, OutFlags=sFlags'(20).
- Handshake and reset:
  - InStart pulsed 5 cycles into an operation is ignored; the first result is unaffected.
  - InStart in the OutDone cycle starts a second operation that completes 17 cycles later.
  - Reset at cycle 8 of an operation -> next cycle OutBusy=0 and all outputs 0, and no OutDone follows.
